// File: rtl/bus_interface.sv
// Memory bus front end: arbitrates CPU and debug bus cycles, launches registered
// strobes from the bus-sequence code, and captures read data back to the requester.
module bus_interface (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FETCH,
  input  logic        DECODE,
  input  logic        EXECUTE,
  input  logic        COMMIT,
  input  logic [2:0]  BUS_SEQX,
  output logic [15:0] CPU_DIN,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_DOUT,
  input  logic        CPU_BYTEX,
  output logic        RD_BUF,
  output logic        WR0_BUF,
  output logic        WR1_BUF,
  output logic [15:0] ADDR_BUF,
  output logic [15:0] DOUT_BUF,
  input  logic [15:0] DIN_BUF,
  output logic        DEBUG_RD,
  output logic        DEBUG_WR,
  output logic        DEBUG_DATA_SELX,
  output logic [15:0] DEBUG_DIN,
  input  logic [15:0] DEBUG_DOUT,
  input  logic [15:0] DEBUG_ADDR
);

  localparam logic [2:0] SEQ_IFETCH = 3'b001;
  localparam logic [2:0] SEQ_ARGRD  = 3'b010;
  localparam logic [2:0] SEQ_ARGWR  = 3'b011;
  localparam logic [2:0] SEQ_RSVD   = 3'b100;
  localparam logic [2:0] SEQ_DFETCH = 3'b101;
  localparam logic [2:0] SEQ_DARGRD = 3'b110;
  localparam logic [2:0] SEQ_DARGWR = 3'b111;

  // Phase flags are accepted for interface compatibility only.
  logic unused_phase;
  assign unused_phase = ^{FETCH, DECODE, EXECUTE, COMMIT};

  logic        is_dbg;
  logic        is_rd;
  logic        is_wr;
  logic        wr0_nxt;
  logic        wr1_nxt;
  logic [15:0] addr_nxt;
  logic [15:0] dout_nxt;
  logic        byte_p0;

  // Byte reads return the addressed lane zero-extended; word reads pass through.
  function automatic logic [15:0] cpu_capture(input logic [15:0] din,
                                              input logic        byte_mode,
                                              input logic        odd);
    if (!byte_mode)
      return din;
    else if (odd)
      return {8'h00, din[15:8]};
    else
      return {8'h00, din[7:0]};
  endfunction

  // Stage p0 inputs: decode bus code and select source
  always_comb begin
    is_dbg   = BUS_SEQX[2] && (BUS_SEQX != SEQ_RSVD);
    is_rd    = (BUS_SEQX == SEQ_IFETCH) || (BUS_SEQX == SEQ_ARGRD) ||
               (BUS_SEQX == SEQ_DFETCH) || (BUS_SEQX == SEQ_DARGRD);
    is_wr    = (BUS_SEQX == SEQ_ARGWR) || (BUS_SEQX == SEQ_DARGWR);
    addr_nxt = is_dbg ? DEBUG_ADDR : CPU_ADDR;
    dout_nxt = is_dbg ? DEBUG_DOUT : CPU_DOUT;
    wr0_nxt  = is_wr;
    wr1_nxt  = is_wr;
    if (is_wr && !is_dbg && CPU_BYTEX) begin
      dout_nxt = {CPU_DOUT[7:0], CPU_DOUT[7:0]};
      wr0_nxt  = !CPU_ADDR[0];
      wr1_nxt  = CPU_ADDR[0];
    end
  end

  // Stage p0 registers: launched strobes; capture of the cycle already on the bus
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RD_BUF          <= 1'b0;
      WR0_BUF         <= 1'b0;
      WR1_BUF         <= 1'b0;
      ADDR_BUF        <= '0;
      DOUT_BUF        <= '0;
      DEBUG_DATA_SELX <= 1'b0;
      DEBUG_RD        <= 1'b0;
      DEBUG_WR        <= 1'b0;
      CPU_DIN         <= '0;
      DEBUG_DIN       <= '0;
      byte_p0         <= 1'b0;
    end else begin
      DEBUG_RD <= RD_BUF && DEBUG_DATA_SELX;
      DEBUG_WR <= (WR0_BUF || WR1_BUF) && DEBUG_DATA_SELX;
      if (RD_BUF) begin
        if (DEBUG_DATA_SELX)
          DEBUG_DIN <= DIN_BUF;
        else
          CPU_DIN <= cpu_capture(DIN_BUF, byte_p0, ADDR_BUF[0]);
      end

      RD_BUF          <= is_rd;
      WR0_BUF         <= wr0_nxt;
      WR1_BUF         <= wr1_nxt;
      DEBUG_DATA_SELX <= is_dbg;
      if (is_rd || is_wr) begin
        ADDR_BUF <= addr_nxt;
        byte_p0  <= CPU_BYTEX && !is_dbg;
      end
      if (is_wr)
        DOUT_BUF <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_interface.sv
// Bench for bus_interface: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_bus_interface;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FETCH, DECODE, EXECUTE, COMMIT;
  logic [2:0]  BUS_SEQX;
  logic [15:0] CPU_DIN, CPU_ADDR, CPU_DOUT;
  logic        CPU_BYTEX;
  logic        RD_BUF, WR0_BUF, WR1_BUF;
  logic [15:0] ADDR_BUF, DOUT_BUF, DIN_BUF;
  logic        DEBUG_RD, DEBUG_WR, DEBUG_DATA_SELX;
  logic [15:0] DEBUG_DIN, DEBUG_DOUT, DEBUG_ADDR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  bus_interface dut (
    .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .EXECUTE(EXECUTE),
    .COMMIT(COMMIT), .BUS_SEQX(BUS_SEQX), .CPU_DIN(CPU_DIN), .CPU_ADDR(CPU_ADDR),
    .CPU_DOUT(CPU_DOUT), .CPU_BYTEX(CPU_BYTEX), .RD_BUF(RD_BUF), .WR0_BUF(WR0_BUF),
    .WR1_BUF(WR1_BUF), .ADDR_BUF(ADDR_BUF), .DOUT_BUF(DOUT_BUF), .DIN_BUF(DIN_BUF),
    .DEBUG_RD(DEBUG_RD), .DEBUG_WR(DEBUG_WR), .DEBUG_DATA_SELX(DEBUG_DATA_SELX),
    .DEBUG_DIN(DEBUG_DIN), .DEBUG_DOUT(DEBUG_DOUT), .DEBUG_ADDR(DEBUG_ADDR)
  );

  // Reference model: tracks the bus transaction in flight and what each requester last saw.
  bit      m_rd, m_wr0, m_wr1, m_sel, m_dbg_rd, m_dbg_wr, m_byte;
  int      m_addr, m_dout, m_cpu_din, m_dbg_din;

  task automatic model_edge();
    int code, din;
    bit kind_dbg, kind_rd, kind_wr;
    code = BUS_SEQX;
    din  = DIN_BUF;
    if (RESET) begin
      {m_rd, m_wr0, m_wr1, m_sel, m_dbg_rd, m_dbg_wr, m_byte} = '0;
      m_addr = 0; m_dout = 0; m_cpu_din = 0; m_dbg_din = 0;
      return;
    end
    // Finish the transaction that was on the bus during the cycle just ended.
    m_dbg_rd = m_rd && m_sel;
    m_dbg_wr = (m_wr0 || m_wr1) && m_sel;
    if (m_rd && m_sel) m_dbg_din = din;
    if (m_rd && !m_sel) begin
      if (!m_byte)            m_cpu_din = din;
      else if (m_addr % 2)    m_cpu_din = din / 256;
      else                    m_cpu_din = din % 256;
    end
    // Start the transaction requested now.
    kind_dbg = (code >= 5);
    kind_rd  = (code == 1) || (code == 2) || (code == 5) || (code == 6);
    kind_wr  = (code == 3) || (code == 7);
    m_sel = kind_dbg;
    m_rd  = kind_rd;
    m_wr0 = 0; m_wr1 = 0;
    if (kind_rd || kind_wr) begin
      m_addr = kind_dbg ? int'(DEBUG_ADDR) : int'(CPU_ADDR);
      m_byte = !kind_dbg && CPU_BYTEX;
    end
    if (kind_wr) begin
      if (kind_dbg)        begin m_dout = DEBUG_DOUT; m_wr0 = 1; m_wr1 = 1; end
      else if (!CPU_BYTEX) begin m_dout = CPU_DOUT;   m_wr0 = 1; m_wr1 = 1; end
      else begin
        m_dout = (CPU_DOUT % 256) * 257;
        m_wr0  = (CPU_ADDR % 2) == 0;
        m_wr1  = (CPU_ADDR % 2) == 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    RESET = 1; BUS_SEQX = 3'b000; CPU_BYTEX = 0;
    CPU_ADDR = 16'h1111; CPU_DOUT = 16'h2222; DIN_BUF = 16'h3333;
    DEBUG_DOUT = 16'h4444; DEBUG_ADDR = 16'h5555;
    tick();
    n_checks++;
    if ({RD_BUF, WR0_BUF, WR1_BUF, DEBUG_RD, DEBUG_WR, DEBUG_DATA_SELX} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {RD_BUF, WR0_BUF, WR1_BUF, DEBUG_RD, DEBUG_WR, DEBUG_DATA_SELX});
    end
    n_checks++;
    if ({ADDR_BUF, DOUT_BUF, CPU_DIN, DEBUG_DIN} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h %h want all 0000",
        ADDR_BUF, DOUT_BUF, CPU_DIN, DEBUG_DIN);
    end
    RESET = 0;
    tick();
    n_checks++;
    if ({RD_BUF, WR0_BUF, WR1_BUF, CPU_DIN, DEBUG_DIN} !== 35'h0) begin
      n_fail++; $display("FAIL idle_after_reset: strobes %b cpu_din %h dbg_din %h want 0",
        {RD_BUF, WR0_BUF, WR1_BUF}, CPU_DIN, DEBUG_DIN);
    end
  endtask

  task automatic test_cpu_read();
    BUS_SEQX = 3'b001;
    tick();
    n_checks++;
    if (RD_BUF !== 1'b1 || ADDR_BUF !== 16'h1111) begin
      n_fail++; $display("FAIL ifetch_launch: rd %b addr %h want 1 1111", RD_BUF, ADDR_BUF);
    end
    BUS_SEQX = 3'b010;
    tick();
    n_checks++;
    if (RD_BUF !== 1'b1 || CPU_DIN !== 16'h3333) begin
      n_fail++; $display("FAIL argrd_b2b: rd %b cpu_din %h want 1 3333", RD_BUF, CPU_DIN);
    end
    BUS_SEQX = 3'b000;
    tick();
    n_checks++;
    if (RD_BUF !== 1'b0 || CPU_DIN !== 16'h3333 || DEBUG_DIN !== 16'h0000) begin
      n_fail++; $display("FAIL read_end: rd %b cpu_din %h dbg_din %h want 0 3333 0000",
        RD_BUF, CPU_DIN, DEBUG_DIN);
    end
  endtask

  task automatic test_word_write();
    BUS_SEQX = 3'b011;
    tick();
    n_checks++;
    if ({RD_BUF, WR0_BUF, WR1_BUF} !== 3'b011 || ADDR_BUF !== 16'h1111 || DOUT_BUF !== 16'h2222) begin
      n_fail++; $display("FAIL word_write: strobes %b addr %h dout %h want 011 1111 2222",
        {RD_BUF, WR0_BUF, WR1_BUF}, ADDR_BUF, DOUT_BUF);
    end
    BUS_SEQX = 3'b000;
    tick();
    n_checks++;
    if ({WR0_BUF, WR1_BUF} !== 2'b00 || DOUT_BUF !== 16'h2222) begin
      n_fail++; $display("FAIL word_write_end: wr %b dout %h want 00 2222", {WR0_BUF, WR1_BUF}, DOUT_BUF);
    end
  endtask

  task automatic test_byte();
    CPU_BYTEX = 1; BUS_SEQX = 3'b011;
    tick();
    n_checks++;
    if ({WR0_BUF, WR1_BUF} !== 2'b01 || DOUT_BUF !== 16'h2222) begin
      n_fail++; $display("FAIL byte_write_odd: wr %b dout %h want 01 2222", {WR0_BUF, WR1_BUF}, DOUT_BUF);
    end
    BUS_SEQX = 3'b010; DIN_BUF = 16'h3344;
    tick();
    BUS_SEQX = 3'b000; CPU_BYTEX = 0;   // byte mode must stay latched with the strobe
    tick();
    n_checks++;
    if (CPU_DIN !== 16'h0033) begin
      n_fail++; $display("FAIL byte_read_odd: cpu_din %h want 0033", CPU_DIN);
    end
    CPU_BYTEX = 1; CPU_ADDR = 16'h1110; BUS_SEQX = 3'b010;
    tick();
    BUS_SEQX = 3'b011; CPU_DOUT = 16'h12ab;
    tick();
    n_checks++;
    if (CPU_DIN !== 16'h0044) begin
      n_fail++; $display("FAIL byte_read_even: cpu_din %h want 0044", CPU_DIN);
    end
    n_checks++;
    if ({WR0_BUF, WR1_BUF} !== 2'b10 || DOUT_BUF !== 16'habab) begin
      n_fail++; $display("FAIL byte_write_even: wr %b dout %h want 10 abab", {WR0_BUF, WR1_BUF}, DOUT_BUF);
    end
    BUS_SEQX = 3'b000; CPU_BYTEX = 0; CPU_ADDR = 16'h1111; CPU_DOUT = 16'h2222;
    tick();
  endtask

  task automatic test_debug_read();
    DIN_BUF = 16'h3333; BUS_SEQX = 3'b101;
    tick();
    n_checks++;
    if (ADDR_BUF !== 16'h5555 || DEBUG_DATA_SELX !== 1'b1 || RD_BUF !== 1'b1 || DEBUG_RD !== 1'b0) begin
      n_fail++; $display("FAIL dfetch_launch: addr %h sel %b rd %b dbg_rd %b want 5555 1 1 0",
        ADDR_BUF, DEBUG_DATA_SELX, RD_BUF, DEBUG_RD);
    end
    BUS_SEQX = 3'b110;
    tick();
    n_checks++;
    if (DEBUG_RD !== 1'b1 || DEBUG_DIN !== 16'h3333 || CPU_DIN !== 16'h0044) begin
      n_fail++; $display("FAIL dfetch_capture: dbg_rd %b dbg_din %h cpu_din %h want 1 3333 0044",
        DEBUG_RD, DEBUG_DIN, CPU_DIN);
    end
    BUS_SEQX = 3'b000;
    tick();
    n_checks++;
    if (DEBUG_RD !== 1'b1 || DEBUG_DATA_SELX !== 1'b0 || CPU_DIN !== 16'h0044) begin
      n_fail++; $display("FAIL dargrd_capture: dbg_rd %b sel %b cpu_din %h want 1 0 0044",
        DEBUG_RD, DEBUG_DATA_SELX, CPU_DIN);
    end
    tick();
    n_checks++;
    if (DEBUG_RD !== 1'b0 || DEBUG_DIN !== 16'h3333) begin
      n_fail++; $display("FAIL dbg_rd_end: dbg_rd %b dbg_din %h want 0 3333", DEBUG_RD, DEBUG_DIN);
    end
  endtask

  task automatic test_debug_write_reset();
    BUS_SEQX = 3'b111;
    tick();
    n_checks++;
    if ({WR0_BUF, WR1_BUF} !== 2'b11 || DOUT_BUF !== 16'h4444 || ADDR_BUF !== 16'h5555 || DEBUG_WR !== 1'b0) begin
      n_fail++; $display("FAIL dargwr: wr %b dout %h addr %h dbg_wr %b want 11 4444 5555 0",
        {WR0_BUF, WR1_BUF}, DOUT_BUF, ADDR_BUF, DEBUG_WR);
    end
    tick();
    n_checks++;
    if (DEBUG_WR !== 1'b1 || {WR0_BUF, WR1_BUF} !== 2'b11) begin
      n_fail++; $display("FAIL dbg_wr_pulse: dbg_wr %b wr %b want 1 11", DEBUG_WR, {WR0_BUF, WR1_BUF});
    end
    RESET = 1;
    tick();
    n_checks++;
    if ({RD_BUF, WR0_BUF, WR1_BUF, DEBUG_RD, DEBUG_WR, DEBUG_DATA_SELX} !== 6'b0 ||
        {ADDR_BUF, DOUT_BUF, CPU_DIN, DEBUG_DIN} !== 64'h0) begin
      n_fail++; $display("FAIL reset_abort: ctrl %b data %h %h %h %h want all 0",
        {RD_BUF, WR0_BUF, WR1_BUF, DEBUG_RD, DEBUG_WR, DEBUG_DATA_SELX},
        ADDR_BUF, DOUT_BUF, CPU_DIN, DEBUG_DIN);
    end
    RESET = 0; BUS_SEQX = 3'b000;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET      = ($urandom_range(0, 49) == 0);
      BUS_SEQX   = 3'($urandom_range(0, 7));
      CPU_BYTEX  = 1'($urandom_range(0, 1));
      CPU_ADDR   = 16'($urandom);
      CPU_DOUT   = 16'($urandom);
      DIN_BUF    = 16'($urandom);
      DEBUG_ADDR = 16'($urandom);
      DEBUG_DOUT = 16'($urandom);
      FETCH = 1'($urandom); DECODE = 1'($urandom); EXECUTE = 1'($urandom); COMMIT = 1'($urandom);
      tick();
      n_checks++;
      if ({RD_BUF, WR0_BUF, WR1_BUF, DEBUG_DATA_SELX, DEBUG_RD, DEBUG_WR} !==
          {m_rd, m_wr0, m_wr1, m_sel, m_dbg_rd, m_dbg_wr}) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
          {RD_BUF, WR0_BUF, WR1_BUF, DEBUG_DATA_SELX, DEBUG_RD, DEBUG_WR},
          {m_rd, m_wr0, m_wr1, m_sel, m_dbg_rd, m_dbg_wr});
      end
      n_checks++;
      if (ADDR_BUF !== 16'(m_addr)) begin
        n_fail++; $display("FAIL rand_addr[%0d]: got %h want %h", i, ADDR_BUF, 16'(m_addr));
      end
      n_checks++;
      if (DOUT_BUF !== 16'(m_dout)) begin
        n_fail++; $display("FAIL rand_dout[%0d]: got %h want %h", i, DOUT_BUF, 16'(m_dout));
      end
      n_checks++;
      if (CPU_DIN !== 16'(m_cpu_din)) begin
        n_fail++; $display("FAIL rand_cpu_din[%0d]: got %h want %h", i, CPU_DIN, 16'(m_cpu_din));
      end
      n_checks++;
      if (DEBUG_DIN !== 16'(m_dbg_din)) begin
        n_fail++; $display("FAIL rand_dbg_din[%0d]: got %h want %h", i, DEBUG_DIN, 16'(m_dbg_din));
      end
    end
  endtask

  initial begin
    FETCH = 0; DECODE = 0; EXECUTE = 0; COMMIT = 0;
    RESET = 1; BUS_SEQX = 3'b000; CPU_BYTEX = 0;
    CPU_ADDR = 0; CPU_DOUT = 0; DIN_BUF = 0; DEBUG_DOUT = 0; DEBUG_ADDR = 0;
    #1;
    test_reset();
    test_cpu_read();
    test_word_write();
    test_byte();
    test_debug_read();
    test_debug_write_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
